uart_rx_multi: RTL and testbench

Parametrised UART receive engine replacing the fixed 8-bit, even-parity receiver. It runs on a single system clock and is paced by an oversampling tick enable. It synchronises the serial input, rejects false starts, majority-votes each bit at mid-cell, and supports 5–9 data bits, none/even/odd parity and 1 or 2 stop bits. Each received word is presented on a valid/ready holding register, together with per-word parity and framing flags and an overrun pulse; it feeds the UART host-side FIFO.

---
 rtl/uart_rx_multi_if.sv | 30 +++
 rtl/uart_rx_multi.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_multi.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_multi_if.sv
// Receive-side holding register bundle: word, flags and valid/ready.
// master = the receiver, slave = the consuming FIFO.
interface uart_rx_multi_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_multi.sv
// Oversampled UART receiver: 5..9 data bits, none/even/odd parity,
// 1 or 2 stop bits, majority-voted mid-cell sampling, valid/ready output.
module uart_rx_multi #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic clk2,
  input  logic rst,
  input  logic baud_tick,
  input  logic rx,
  output logic busy,
  uart_rx_multi_if.master bus
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BIW = 4;

  localparam logic [TCW-1:0] SMP0  = TCW'(OVERSAMPLE/2 - 1);
  localparam logic [TCW-1:0] SMP1  = TCW'(OVERSAMPLE/2);
  localparam logic [TCW-1:0] SMP2  = TCW'(OVERSAMPLE/2 + 1);
  localparam logic [TCW-1:0] TLAST = TCW'(OVERSAMPLE - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic                 rx_meta_q;
  logic                 rs_q;

  logic [2:0]           state_q, state_d;
  logic [TCW-1:0]       tc_q, tc_d;
  logic [BIW-1:0]       bi_q, bi_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [1:0]           smp_q, smp_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;

  logic [TCW-1:0]       tpos;
  logic                 maj;
  logic                 decide;
  logic                 done;
  logic                 done_fe;

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rs_q      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rs_q      <= rx_meta_q;
    end
  end

  // tpos is this tick's position in the cell; tc_q holds the previous one
  assign tpos   = (tc_q == TLAST) ? '0 : tc_q + 1'b1;
  assign decide = (tpos == SMP2);
  assign maj    = (smp_q[0] & smp_q[1])
                | (smp_q[0] & rs_q)
                | (smp_q[1] & rs_q);

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    bi_d    = bi_q;
    sh_d    = sh_q;
    smp_d   = smp_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    done_fe = ferr_q;
    if (baud_tick) begin
      if (state_q == IDLE) begin
        if (!rs_q) begin
          state_d = START;
          tc_d    = '0;
          bi_d    = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end else begin
        tc_d = tpos;
        if (tpos == SMP0) smp_d[0] = rs_q;
        if (tpos == SMP1) smp_d[1] = rs_q;
        unique case (state_q)
          START: begin
            if (decide && maj) begin
              state_d = IDLE;
            end else if (tpos == TLAST) begin
              state_d = DATA;
            end
          end
          DATA: begin
            if (decide) begin
              sh_d = {maj, sh_q[DATA_BITS-1:1]};
              bi_d = bi_q + 1'b1;
            end
            if (tpos == TLAST && bi_q == BIW'(DATA_BITS)) begin
              bi_d    = '0;
              state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            end
          end
          PARITY: begin
            if (decide) begin
              perr_d = ^sh_q ^ maj ^ (PARITY_MODE == 2);
            end
            if (tpos == TLAST) state_d = STOP;
          end
          STOP: begin
            if (decide) begin
              if (!maj) ferr_d = 1'b1;
              // last stop decision ends the frame; the rest of the
              // cell is spent in IDLE so an early start edge is seen
              if (bi_q == BIW'(STOP_BITS - 1)) begin
                done    = 1'b1;
                done_fe = ferr_q | ~maj;
                state_d = IDLE;
                bi_d    = '0;
                tc_d    = '0;
              end else begin
                bi_d = bi_q + 1'b1;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = 1'b0;
    if (valid_q && bus.rx_ready) valid_d = 1'b0;
    if (done) begin
      if (!valid_q || bus.rx_ready) begin
        data_d  = sh_q;
        pe_d    = perr_q;
        fe_d    = done_fe;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tc_q    <= '0;
      bi_q    <= '0;
      sh_q    <= '0;
      smp_q   <= 2'b11;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      bi_q    <= bi_d;
      sh_q    <= sh_d;
      smp_q   <= smp_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err  = fe_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_multi.sv
// Bench for uart_rx_multi: 8N1, 8E1 and 7O2 receivers on one tick,
// table-driven frames plus latency, glitch, overrun and reset sequences.
module tb_uart_rx_multi;

  localparam int OS = 16;

  logic clk2 = 1'b0;
  logic rst  = 1'b1;
  logic baud_tick = 1'b0;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic rx2 = 1'b1;
  logic busy0, busy1, busy2;

  int errors = 0;
  int checks = 0;
  int ovr[3] = '{0, 0, 0};
  int div = 0;

  uart_rx_multi_if #(.DATA_BITS(8)) u0 ();
  uart_rx_multi_if #(.DATA_BITS(8)) u1 ();
  uart_rx_multi_if #(.DATA_BITS(7)) u2 ();

  uart_rx_multi #(
    .DATA_BITS(8), .PARITY_MODE(0),
    .STOP_BITS(1), .OVERSAMPLE(OS)
  ) dut0 (
    .clk2(clk2), .rst(rst), .baud_tick(baud_tick),
    .rx(rx0), .busy(busy0), .bus(u0.master)
  );

  uart_rx_multi #(
    .DATA_BITS(8), .PARITY_MODE(1),
    .STOP_BITS(1), .OVERSAMPLE(OS)
  ) dut1 (
    .clk2(clk2), .rst(rst), .baud_tick(baud_tick),
    .rx(rx1), .busy(busy1), .bus(u1.master)
  );

  uart_rx_multi #(
    .DATA_BITS(7), .PARITY_MODE(2),
    .STOP_BITS(2), .OVERSAMPLE(OS)
  ) dut2 (
    .clk2(clk2), .rst(rst), .baud_tick(baud_tick),
    .rx(rx2), .busy(busy2), .bus(u2.master)
  );

  always #5 clk2 = ~clk2;

  // one tick every 4 clocks, changed on the falling edge
  always @(negedge clk2) begin
    baud_tick = (div == 3);
    div = (div + 1) % 4;
  end

  typedef struct {
    int         dut;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    int         dut;
    int         nbits;
    logic [8:0] data;
    logic       has_par;
    logic       pbit;
    int         nstop;
    logic [1:0] stops;
    int         glitch;
    logic [8:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic got_word(input int d, input logic [8:0] data,
                          input logic pe, input logic fe);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_word: dut%0d got %0h expected none",
               d, data);
    end else begin
      e = sbq.pop_front();
      chk("word_dut", d, e.dut);
      chk("word_data", data, e.data);
      chk("word_parity_err", pe, e.pe);
      chk("word_frame_err", fe, e.fe);
    end
  endtask

  always @(negedge clk2) begin
    if (u0.overrun) ovr[0]++;
    if (u1.overrun) ovr[1]++;
    if (u2.overrun) ovr[2]++;
    if (u0.rx_valid && u0.rx_ready)
      got_word(0, u0.rx_data, u0.parity_err, u0.frame_err);
    if (u1.rx_valid && u1.rx_ready)
      got_word(1, u1.rx_data, u1.parity_err, u1.frame_err);
    if (u2.rx_valid && u2.rx_ready)
      got_word(2, 9'(u2.rx_data), u2.parity_err, u2.frame_err);
  end

  task automatic next_tick();
    do @(posedge clk2); while (baud_tick !== 1'b1);
  endtask

  task automatic set_rx(input int d, input logic v);
    case (d)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic wait_busy0();
    int n;
    n = 0;
    do begin
      @(posedge clk2);
      #1;
      n++;
    end while (!busy0 && n < 400);
    if (!busy0) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got 0 expected 1 within 400 cycles");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, u0.rx_data, 0);
    chk({tag, "_valid"}, u0.rx_valid, 0);
    chk({tag, "_perr"}, u0.parity_err, 0);
    chk({tag, "_ferr"}, u0.frame_err, 0);
    chk({tag, "_ovr"}, u0.overrun, 0);
    chk({tag, "_busy"}, busy0, 0);
  endtask

  // drives one frame cell by cell, each cell exactly OS ticks long
  task automatic send_frame(input int d, input int nbits,
                            input logic [8:0] data,
                            input logic has_par, input logic pbit,
                            input int nstop, input logic [1:0] stops,
                            input int glitch, input int abort_c);
    logic line [16];
    int   nc;
    logic lv;
    nc = 0;
    line[nc] = 1'b0;
    nc++;
    for (int i = 0; i < nbits; i++) begin
      line[nc] = data[i];
      nc++;
    end
    if (has_par) begin
      line[nc] = pbit;
      nc++;
    end
    for (int i = 0; i < nstop; i++) begin
      line[nc] = stops[i];
      nc++;
    end
    next_tick();
    #1;
    for (int c = 0; c < nc; c++) begin
      lv = line[c];
      set_rx(d, lv);
      for (int k = 0; k < OS; k++) begin
        next_tick();
        #1;
        if (c == glitch && k == 7) set_rx(d, 1'b0);
        if (c == glitch && k == 8) set_rx(d, lv);
        if (c == abort_c && k == 8) begin
          rst = 1'b0;
          #1;
          check_reset_outputs("rst_mid");
          repeat (3) @(posedge clk2);
          set_rx(d, 1'b1);
          #1;
          rst = 1'b1;
          repeat (2 * OS) next_tick();
          #1;
          return;
        end
      end
    end
    set_rx(d, 1'b1);
    repeat (2 * OS) next_tick();
    #1;
  endtask

  vec_t tv[11];
  int   base;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{0, 8, 9'h0A5, 0, 0, 1, 2'b11, -1, 9'h0A5, 0, 0};
    tv[1]  = '{0, 8, 9'h000, 0, 0, 1, 2'b11, -1, 9'h000, 0, 0};
    tv[2]  = '{0, 8, 9'h0FF, 0, 0, 1, 2'b10, -1, 9'h0FF, 0, 1};
    tv[3]  = '{0, 8, 9'h001, 0, 0, 1, 2'b11,  1, 9'h001, 0, 0};
    tv[4]  = '{1, 8, 9'h03C, 1, 0, 1, 2'b11, -1, 9'h03C, 0, 0};
    tv[5]  = '{1, 8, 9'h03C, 1, 1, 1, 2'b11, -1, 9'h03C, 1, 0};
    tv[6]  = '{1, 8, 9'h007, 1, 1, 1, 2'b11, -1, 9'h007, 0, 0};
    tv[7]  = '{2, 7, 9'h041, 1, 1, 2, 2'b01, -1, 9'h041, 0, 1};
    tv[8]  = '{2, 7, 9'h07F, 1, 0, 2, 2'b11, -1, 9'h07F, 0, 0};
    tv[9]  = '{2, 7, 9'h02A, 1, 1, 2, 2'b11, -1, 9'h02A, 1, 0};
    tv[10] = '{2, 7, 9'h041, 1, 1, 2, 2'b10, -1, 9'h041, 0, 1};

    u0.rx_ready = 1'b1;
    u1.rx_ready = 1'b1;
    u2.rx_ready = 1'b1;

    #2 rst = 1'b0;
    #20;
    check_reset_outputs("rst_init");
    @(posedge clk2);
    #1 rst = 1'b1;
    repeat (4) next_tick();

    // first-word latency: valid rises in the cycle after tick D+153
    sbq.push_back('{0, 9'h0A5, 1'b0, 1'b0});
    fork
      send_frame(0, 8, 9'h0A5, 0, 0, 1, 2'b11, -1, -1);
      begin
        wait_busy0();
        repeat (152) next_tick();
        repeat (3) @(posedge clk2);
        #1 chk("lat_valid_before", u0.rx_valid, 0);
        @(posedge clk2);
        #1 chk("lat_valid_after", u0.rx_valid, 1);
      end
    join

    for (int i = 0; i < 11; i++) begin
      sbq.push_back('{tv[i].dut, tv[i].exp_data,
                      tv[i].exp_pe, tv[i].exp_fe});
      send_frame(tv[i].dut, tv[i].nbits, tv[i].data,
                 tv[i].has_par, tv[i].pbit, tv[i].nstop,
                 tv[i].stops, tv[i].glitch, -1);
    end

    // five-tick false start
    fork
      begin
        next_tick();
        #1 set_rx(0, 1'b0);
        repeat (5) next_tick();
        #1 set_rx(0, 1'b1);
      end
      begin
        wait_busy0();
        repeat (8) next_tick();
        #1 chk("glitch_busy_d8", busy0, 1);
        next_tick();
        #1 chk("glitch_busy_d9", busy0, 0);
      end
    join
    repeat (2 * OS) next_tick();
    #1 chk("glitch_no_valid", u0.rx_valid, 0);

    // overrun with consumer stalled
    base = ovr[0];
    u0.rx_ready = 1'b0;
    sbq.push_back('{0, 9'h011, 1'b0, 1'b0});
    send_frame(0, 8, 9'h011, 0, 0, 1, 2'b11, -1, -1);
    send_frame(0, 8, 9'h022, 0, 0, 1, 2'b11, -1, -1);
    chk("ovr_data_kept", u0.rx_data, 32'h11);
    chk("ovr_valid_held", u0.rx_valid, 1);
    chk("ovr_pulses", ovr[0] - base, 1);
    u0.rx_ready = 1'b1;
    @(posedge clk2);
    #1 chk("ovr_valid_drop", u0.rx_valid, 0);

    // reset during data bit 4 of 0xFF, then a clean frame
    send_frame(0, 8, 9'h0FF, 0, 0, 1, 2'b11, -1, 5);
    chk("post_rst_valid", u0.rx_valid, 0);
    sbq.push_back('{0, 9'h05A, 1'b0, 1'b0});
    send_frame(0, 8, 9'h05A, 0, 0, 1, 2'b11, -1, -1);

    chk("sb_empty", sbq.size(), 0);
    chk("ovr_dut1", ovr[1], 0);
    chk("ovr_dut2", ovr[2], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
